// File: rtl/mcp_run_controller_if.sv
// Signal bundle between the run sequencer and the UART/core fabric.
// The controller side is "master"; the surrounding fabric is "slave".
interface mcp_run_controller_if #(
  parameter int CORE_COUNT      = 4,
  parameter int CYCLE_CNT_WIDTH = 26,
  parameter int RUN_CNT_WIDTH   = 8
);
  // Completion inputs are single-cycle pulses sampled on the rising clock edge.
  // process_start and tx_startN are one-cycle registered strobes.
  // The controller never waits on a ready, so every strobe is fire-and-forget.
  logic                       startN;
  logic                       abort;
  logic                       keep_imem;
  logic [CORE_COUNT-1:0]      core_en;
  logic [CORE_COUNT-1:0]      core_done;
  logic                       ins_received;
  logic                       data_received;
  logic                       data_transmitted;
  logic [2:0]                 state;
  logic                       rx_ins_en;
  logic                       rx_data_en;
  logic                       uart_dmem_sel;
  logic                       core_mem_sel;
  logic                       process_start;
  logic                       tx_startN;
  logic                       busy;
  logic                       error;
  logic [CYCLE_CNT_WIDTH-1:0] exec_cycles;
  logic [RUN_CNT_WIDTH-1:0]   run_count;

  modport master (
    input  startN, abort, keep_imem, core_en, core_done,
           ins_received, data_received, data_transmitted,
    output state, rx_ins_en, rx_data_en, uart_dmem_sel, core_mem_sel,
           process_start, tx_startN, busy, error, exec_cycles, run_count
  );

  modport slave (
    output startN, abort, keep_imem, core_en, core_done,
           ins_received, data_received, data_transmitted,
    input  state, rx_ins_en, rx_data_en, uart_dmem_sel, core_mem_sel,
           process_start, tx_startN, busy, error, exec_cycles, run_count
  );
endinterface

// File: rtl/mcp_run_controller.sv
// Run sequencer: imem load, dmem load, multi-core execution, result transmit,
// with done aggregation, execution timeout, abort and run statistics.
module mcp_run_controller #(
  parameter int CORE_COUNT      = 4,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int CYCLE_CNT_WIDTH = 26,
  parameter int RUN_CNT_WIDTH   = 8
) (
  input logic                clk,
  input logic                rstN,
  mcp_run_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_IMEM = 3'd1,
    S_RX_DMEM = 3'd2,
    S_EXEC    = 3'd3,
    S_TX_DMEM = 3'd4,
    S_FINISH  = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  localparam int EW = CYCLE_CNT_WIDTH + 1;

  state_e                     state_q, state_d;
  logic                       startN_q, startN_d;
  logic                       imem_valid_q, imem_valid_d;
  logic [CORE_COUNT-1:0]      mask_q, mask_d;
  logic [CORE_COUNT-1:0]      done_sticky_q, done_sticky_d;
  logic [CYCLE_CNT_WIDTH-1:0] exec_cycles_q, exec_cycles_d;
  logic [RUN_CNT_WIDTH-1:0]   run_count_q, run_count_d;
  logic                       process_start_q, process_start_d;
  logic                       tx_startN_q, tx_startN_d;
  logic                       error_q, error_d;

  logic          start_fall;
  logic          all_done;
  logic          timeout_hit;
  logic          abortable;
  logic [EW-1:0] exec_next_cnt;

  assign start_fall    = startN_q & ~bus.startN;
  assign all_done      = ((done_sticky_q | bus.core_done) & mask_q) == mask_q;
  assign exec_next_cnt = {1'b0, exec_cycles_q} + EW'(1);
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (exec_next_cnt == EW'(TIMEOUT_CYCLES));
  assign abortable     = (state_q == S_RX_IMEM) || (state_q == S_RX_DMEM) ||
                         (state_q == S_EXEC)    || (state_q == S_TX_DMEM);

  always_comb begin
    state_d         = state_q;
    startN_d        = bus.startN;
    imem_valid_d    = imem_valid_q;
    mask_d          = mask_q;
    done_sticky_d   = done_sticky_q;
    exec_cycles_d   = exec_cycles_q;
    run_count_d     = run_count_q;
    process_start_d = 1'b0;
    tx_startN_d     = 1'b1;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start_fall) begin
          state_d = (bus.keep_imem && imem_valid_q) ? S_RX_DMEM : S_RX_IMEM;
        end
      end
      S_RX_IMEM: begin
        if (bus.ins_received) begin
          state_d      = S_RX_DMEM;
          imem_valid_d = 1'b1;
        end
      end
      S_RX_DMEM: begin
        if (bus.data_received) begin
          state_d         = S_EXEC;
          // An empty enable mask means "wait for every core".
          mask_d          = (bus.core_en == '0) ? '1 : bus.core_en;
          done_sticky_d   = '0;
          exec_cycles_d   = '0;
          process_start_d = 1'b1;
        end
      end
      S_EXEC: begin
        exec_cycles_d = (exec_cycles_q == '1) ? exec_cycles_q
                                              : exec_cycles_q + CYCLE_CNT_WIDTH'(1);
        done_sticky_d = done_sticky_q | (bus.core_done & mask_q);
        if (all_done) begin
          state_d     = S_TX_DMEM;
          tx_startN_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_TX_DMEM: begin
        if (bus.data_transmitted) begin
          state_d     = S_FINISH;
          run_count_d = run_count_q + RUN_CNT_WIDTH'(1);
        end
      end
      S_ERROR: begin
        if (start_fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards everything the active state would have done this cycle.
    if (bus.abort && abortable) begin
      state_d         = S_IDLE;
      imem_valid_d    = imem_valid_q;
      mask_d          = mask_q;
      done_sticky_d   = done_sticky_q;
      exec_cycles_d   = exec_cycles_q;
      run_count_d     = run_count_q;
      process_start_d = 1'b0;
      tx_startN_d     = 1'b1;
    end

    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q         <= S_IDLE;
      startN_q        <= 1'b1;
      imem_valid_q    <= 1'b0;
      mask_q          <= '1;
      done_sticky_q   <= '0;
      exec_cycles_q   <= '0;
      run_count_q     <= '0;
      process_start_q <= 1'b0;
      tx_startN_q     <= 1'b1;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      startN_q        <= startN_d;
      imem_valid_q    <= imem_valid_d;
      mask_q          <= mask_d;
      done_sticky_q   <= done_sticky_d;
      exec_cycles_q   <= exec_cycles_d;
      run_count_q     <= run_count_d;
      process_start_q <= process_start_d;
      tx_startN_q     <= tx_startN_d;
      error_q         <= error_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.rx_ins_en     = (state_q == S_RX_IMEM);
  assign bus.rx_data_en    = (state_q == S_RX_DMEM);
  assign bus.uart_dmem_sel = (state_q == S_RX_DMEM) || (state_q == S_TX_DMEM);
  assign bus.core_mem_sel  = (state_q == S_EXEC);
  assign bus.busy          = !((state_q == S_IDLE) || (state_q == S_FINISH) ||
                               (state_q == S_ERROR));
  assign bus.process_start = process_start_q;
  assign bus.tx_startN     = tx_startN_q;
  assign bus.error         = error_q;
  assign bus.exec_cycles   = exec_cycles_q;
  assign bus.run_count     = run_count_q;

endmodule

// File: tb/tb_mcp_run_controller.sv
// Directed bench for mcp_run_controller: stimulus pushes expected state-entry
// snapshots; a negedge monitor pops and compares on every state change.
module tb_mcp_run_controller;

  localparam int CC = 4;
  localparam int CW = 26;
  localparam int RW = 8;
  localparam int TO = 16;
  localparam int OW = 3 + 8 + CW + RW;

  logic clk;
  logic rstN;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mcp_run_controller_if #(.CORE_COUNT(CC), .CYCLE_CNT_WIDTH(CW), .RUN_CNT_WIDTH(RW)) bus ();

  mcp_run_controller #(
    .CORE_COUNT(CC), .TIMEOUT_CYCLES(TO), .CYCLE_CNT_WIDTH(CW), .RUN_CNT_WIDTH(RW)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ps_cnt = 0;
  int tx_cnt = 0;

  // Expected snapshot on entry to state s: decodes, entry strobes, counters.
  function automatic logic [OW-1:0] mk(input logic [2:0] s, input logic [CW-1:0] ex,
                                       input logic [RW-1:0] rc);
    logic rx_i, rx_d, uart, core, busy, err, ps, txl;
    rx_i = (s == 3'd1);
    rx_d = (s == 3'd2);
    uart = (s == 3'd2) || (s == 3'd4);
    core = (s == 3'd3);
    busy = (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    err  = (s == 3'd6);
    ps   = (s == 3'd3);
    txl  = (s == 3'd4);
    return {s, rx_i, rx_d, uart, core, busy, err, ps, txl, ex, rc};
  endfunction

  function automatic logic [OW-1:0] observe();
    return {bus.state, bus.rx_ins_en, bus.rx_data_en, bus.uart_dmem_sel, bus.core_mem_sel,
            bus.busy, bus.error, bus.process_start, ~bus.tx_startN,
            bus.exec_cycles, bus.run_count};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and compares every state change against the queue.
  initial begin
    logic [2:0]    prev;
    logic [OW-1:0] e;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prev = bus.state;
      end else begin
        if (bus.process_start) ps_cnt++;
        if (!bus.tx_startN) tx_cnt++;
        if (bus.state != prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transition: got state %0d expected no change from %0d",
                     bus.state, prev);
          end else begin
            e = exp_q.pop_front();
            check("state_entry", 64'(observe()), 64'(e));
          end
          prev = bus.state;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_press();
    bus.startN = 1'b0;
    tick(1);
    bus.startN = 1'b1;
    tick(1);
  endtask

  task automatic pulse_ins();
    bus.ins_received = 1'b1;
    tick(1);
    bus.ins_received = 1'b0;
  endtask

  task automatic pulse_data();
    bus.data_received = 1'b1;
    tick(1);
    bus.data_received = 1'b0;
  endtask

  task automatic pulse_tx();
    bus.data_transmitted = 1'b1;
    tick(1);
    bus.data_transmitted = 1'b0;
  endtask

  // Keep core_done low for n-1 EXEC cycles, then present done for one cycle.
  task automatic run_exec(input int n, input logic [CC-1:0] done);
    if (n > 1) tick(n - 1);
    bus.core_done = done;
    tick(1);
    bus.core_done = '0;
  endtask

  initial begin
    int ps_before;
    int tx_before;

    bus.startN = 1'b1;
    bus.abort = 1'b0;
    bus.keep_imem = 1'b0;
    bus.core_en = 4'hF;
    bus.core_done = '0;
    bus.ins_received = 1'b0;
    bus.data_received = 1'b0;
    bus.data_transmitted = 1'b0;
    rstN = 1'b0;
    tick(3);
    check("reset_snapshot", 64'(observe()), 64'(mk(3'd0, '0, '0)));
    check("reset_tx_startN", 64'(bus.tx_startN), 64'd1);
    rstN = 1'b1;
    tick(2);

    // Full run: 0->1->2->3->4->5, ten EXEC cycles.
    exp_q.push_back(mk(3'd1, 0, 0));
    start_press();
    pulse_tx();
    tick(2);
    exp_q.push_back(mk(3'd2, 0, 0));
    pulse_ins();
    tick(2);
    exp_q.push_back(mk(3'd3, 0, 0));
    pulse_data();
    exp_q.push_back(mk(3'd4, 10, 0));
    run_exec(10, 4'hF);
    tick(3);
    exp_q.push_back(mk(3'd5, 10, 1));
    pulse_tx();
    tick(2);
    check("run1_process_start_count", 64'(ps_cnt), 64'd1);
    check("run1_tx_start_count", 64'(tx_cnt), 64'd1);

    // Masked run: only cores 0 and 2 required, done pulses at cycles 3 and 7.
    exp_q.push_back(mk(3'd1, 10, 1));
    start_press();
    exp_q.push_back(mk(3'd2, 10, 1));
    pulse_ins();
    bus.core_en = 4'b0101;
    exp_q.push_back(mk(3'd3, 0, 1));
    pulse_data();
    bus.core_en = 4'hF;
    exp_q.push_back(mk(3'd4, 7, 1));
    tick(2);
    bus.core_done = 4'b0001;
    tick(1);
    bus.core_done = '0;
    tick(3);
    bus.core_done = 4'b0100;
    tick(1);
    bus.core_done = '0;
    exp_q.push_back(mk(3'd5, 7, 2));
    tick(2);
    pulse_tx();
    tick(2);

    // Timeout after 16 EXEC cycles, imem reuse skips RX_IMEM.
    bus.keep_imem = 1'b1;
    exp_q.push_back(mk(3'd2, 7, 2));
    start_press();
    exp_q.push_back(mk(3'd3, 0, 2));
    pulse_data();
    exp_q.push_back(mk(3'd6, 16, 2));
    tick(16);
    tick(2);
    bus.abort = 1'b1;
    tick(2);
    bus.abort = 1'b0;
    pulse_data();
    pulse_ins();
    tick(1);
    check("error_flag_held", 64'(bus.error), 64'd1);
    exp_q.push_back(mk(3'd0, 16, 2));
    bus.startN = 1'b0;
    tick(10);
    bus.startN = 1'b1;
    tick(1);
    exp_q.push_back(mk(3'd2, 16, 2));
    start_press();
    exp_q.push_back(mk(3'd0, 16, 2));
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    tick(2);

    // Abort at EXEC cycle 5, even with all cores reporting done.
    tx_before = tx_cnt;
    exp_q.push_back(mk(3'd2, 16, 2));
    start_press();
    exp_q.push_back(mk(3'd3, 0, 2));
    pulse_data();
    tick(4);
    exp_q.push_back(mk(3'd0, 4, 2));
    bus.abort = 1'b1;
    bus.core_done = 4'hF;
    tick(1);
    bus.abort = 1'b0;
    bus.core_done = '0;
    tick(2);
    check("abort_no_tx_start", 64'(tx_cnt), 64'(tx_before));
    check("abort_run_count", 64'(bus.run_count), 64'd2);

    // core_en==0 means all cores; sticky done across two partial pulses.
    exp_q.push_back(mk(3'd2, 4, 2));
    start_press();
    bus.core_en = '0;
    exp_q.push_back(mk(3'd3, 0, 2));
    pulse_data();
    bus.core_en = 4'hF;
    exp_q.push_back(mk(3'd4, 2, 2));
    bus.core_done = 4'b0111;
    tick(1);
    bus.core_done = 4'b1000;
    tick(1);
    bus.core_done = '0;
    exp_q.push_back(mk(3'd5, 2, 3));
    pulse_tx();
    tick(1);
    bus.abort = 1'b1;
    tick(3);
    bus.abort = 1'b0;
    check("abort_in_finish_ignored", 64'(bus.state), 64'd5);

    // Done on the timeout cycle: completion wins.
    exp_q.push_back(mk(3'd2, 2, 3));
    start_press();
    exp_q.push_back(mk(3'd3, 0, 3));
    pulse_data();
    exp_q.push_back(mk(3'd4, 16, 3));
    run_exec(16, 4'hF);
    tick(2);
    check("same_cycle_no_error", 64'(bus.error), 64'd0);
    exp_q.push_back(mk(3'd5, 16, 4));
    pulse_tx();
    tick(2);

    // startN held low 100 cycles gives one run; then async reset mid-EXEC.
    ps_before = ps_cnt;
    exp_q.push_back(mk(3'd2, 16, 4));
    bus.startN = 1'b0;
    tick(100);
    check("held_start_single_run", 64'(bus.state), 64'd2);
    exp_q.push_back(mk(3'd3, 0, 4));
    pulse_data();
    tick(3);
    rstN = 1'b0;
    #2;
    check("async_reset_snapshot", 64'(observe()), 64'(mk(3'd0, '0, '0)));
    check("async_reset_tx_startN", 64'(bus.tx_startN), 64'd1);
    check("held_start_process_starts", 64'(ps_cnt), 64'(ps_before + 1));
    bus.startN = 1'b1;
    tick(2);
    rstN = 1'b1;
    tick(3);
    check("idle_after_reset", 64'(bus.state), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp_run_controller.md
Name: mcp_run_controller

Overview:
- Run sequencer for the N-core matrix processor top level. It steps through instruction-memory load, data-memory load, execution, and result transmission over UART, and drives the memory-ownership selects between the UART interfaces and the cores.
- Successor to the single-shot, core-0-only sequencer. Adds: per-core done aggregation with a run-time enable mask, an execution timeout with an error state, repeated runs with optional instruction-memory reuse, abort, and cycle/run counters.

Parameters:
- CORE_COUNT, 4, number of processor cores monitored.
- TIMEOUT_CYCLES, 0, maximum EXEC cycles before ERROR; 0 disables the timeout.
- CYCLE_CNT_WIDTH, 26, width of exec_cycles.
- RUN_CNT_WIDTH, 8, width of run_count.

Ports:
- clk  in  1  system clock; the only clock.
- rstN  in  1  reset, asynchronous, active-low.
- startN  in  1  start button, active-low, already synchronised; only its falling edge acts.
- abort  in  1  synchronous abort request, active-high level.
- keep_imem  in  1  1 = skip instruction reload when a valid image is already loaded.
- core_en  in  CORE_COUNT  cores required to finish; latched at EXEC entry.
- core_done  in  CORE_COUNT  per-core done, level or pulse.
- ins_received  in  1  pulse: instruction-memory receive complete.
- data_received  in  1  pulse: data-memory receive complete.
- data_transmitted  in  1  pulse: result transmission complete.
- state  out  3  current state encoding.
- rx_ins_en  out  1  gate for instruction-byte strobes (state==RX_IMEM).
- rx_data_en  out  1  gate for data-byte strobes (state==RX_DMEM).
- uart_dmem_sel  out  1  UART owns data memory (RX_DMEM or TX_DMEM).
- core_mem_sel  out  1  cores own instruction and data memory (EXEC).
- process_start  out  1  one-cycle core start pulse.
- tx_startN  out  1  one-cycle active-low transmit start.
- busy  out  1  state not in {IDLE, FINISH, ERROR}.
- error  out  1  high while in ERROR.
- exec_cycles  out  CYCLE_CNT_WIDTH  length of the current or last EXEC.
- run_count  out  RUN_CNT_WIDTH  completed runs.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters 0; imem_valid=0; done_sticky=0.
  - process_start=0, tx_startN=1, error=0.
  - Decode outputs follow state.
- States: IDLE=0, RX_IMEM=1, RX_DMEM=2, EXEC=3, TX_DMEM=4, FINISH=5, ERROR=6. Encoding 7 goes to IDLE next cycle.
- Start detection: startN is registered. start_fall = previous 1 and current 0. Holding startN low never retriggers.
- IDLE or FINISH + start_fall: go to RX_DMEM if keep_imem && imem_valid, else RX_IMEM.
- RX_IMEM + ins_received: go to RX_DMEM; set imem_valid=1.
- RX_DMEM + data_received: go to EXEC.
  - Latch mask = core_en; if core_en==0, latch all-ones.
  - Clear done_sticky and exec_cycles.
  - Registered process_start=1 for exactly the first EXEC cycle.
- EXEC, each cycle:
  - exec_cycles += 1, saturating at all-ones.
  - done_sticky |= core_done & mask.
  - all_done = ((done_sticky | core_done) & mask) == mask.
  - If all_done: go to TX_DMEM; tx_startN=0 for exactly the first TX_DMEM cycle.
  - Else if TIMEOUT_CYCLES!=0 and exec_cycles+1 == TIMEOUT_CYCLES: go to ERROR.
  - all_done wins over timeout in the same cycle.
  - Minimum EXEC length is 1 cycle; exec_cycles then freezes until the next EXEC entry.
- TX_DMEM + data_transmitted: go to FINISH; run_count += 1, wrapping.
- ERROR: error=1. Only start_fall leaves it, to IDLE. imem_valid is preserved.
- abort in RX_IMEM, RX_DMEM, EXEC or TX_DMEM: go to IDLE next cycle.
  - Overrides every other transition.
  - No pulses are issued; counters are not incremented.
  - An abort in IDLE, FINISH or ERROR is ignored.
- Completion pulses (ins_received, data_received, data_transmitted) arriving outside their own state are ignored. core_done outside EXEC is ignored.
- Decode outputs are pure functions of the registered state; no combinational path from inputs to outputs.

Test Plan:
- Reset, then startN fall; ins_received at t=10; data_received at t=20; core_done=4'b1111 at t=30; data_transmitted at t=40.
  - State path 0→1→2→3→4→5.
  - process_start is high only at cycle 21.
  - tx_startN is low only at cycle 31.
  - exec_cycles=10; run_count=1.
- core_en=4'b0101; core_done[0] pulses at EXEC cycle 3, core_done[2] pulses at cycle 7; core_done[1,3] stay 0 → TX_DMEM after cycle 7, exec_cycles=7.
- TIMEOUT_CYCLES=16, no done → ERROR after 16 EXEC cycles, error=1.
  - start_fall → IDLE.
  - A further start_fall with keep_imem=1 → RX_DMEM, skipping RX_IMEM.
- Abort in EXEC at cycle 5 → IDLE next cycle, no tx_startN pulse, run_count unchanged. Abort asserted in FINISH → stays FINISH.
- Same cycle all_done and timeout (TIMEOUT_CYCLES=4, done at cycle 4) → TX_DMEM, error=0.
- startN held low 100 cycles in FINISH → single new run only. rstN pulsed low mid-EXEC → immediate IDLE, all outputs at reset values.
